// File: rtl/m_edge_mc.sv
// m_edge_mc: multi-channel edge detector with pulse stretcher and a
// saturating per-channel event counter with a sticky overflow flag.
// Optional embedded assertions are enabled with `define M_EDGE_MC_SVA_EN.
module m_edge_mc #(
  parameter int unsigned N       = 4,
  parameter int unsigned STRETCH = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_signal,
  input  logic [2*N-1:0]     edge_sel,
  input  logic               clr_cnt,
  output logic [N-1:0]       out_signal,
  output logic [N*CNT_W-1:0] evt_cnt,
  output logic [N-1:0]       ovf
);

  localparam int unsigned     ST_W    = $clog2(STRETCH + 1);
  localparam logic [ST_W-1:0] ST_LOAD = ST_W'(STRETCH);

  logic                  primed;
  logic [N-1:0]          in_q;
  logic [N-1:0]          rise;
  logic [N-1:0]          fall;
  logic [N-1:0]          det;
  logic [ST_W-1:0]       st_cnt [N];
  logic [ST_W-1:0]       st_nxt [N];
  logic [CNT_W-1:0]      cnt    [N];

  // Edge detection per channel; suppressed until the first post-reset sample is taken
  always_comb begin
    rise = in_signal & ~in_q;
    fall = ~in_signal & in_q;
    det  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (primed) begin
        unique case (edge_sel[2*i +: 2])
          2'b01:   det[i] = rise[i];
          2'b10:   det[i] = fall[i];
          2'b11:   det[i] = rise[i] | fall[i];
          default: det[i] = 1'b0;
        endcase
      end
    end
  end

  // Stretch counter next value: a detection reloads (retrigger extends, never adds)
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      st_nxt[i] = st_cnt[i];
      if (det[i])
        st_nxt[i] = ST_LOAD;
      else if (st_cnt[i] != '0)
        st_nxt[i] = st_cnt[i] - ST_W'(1);
    end
  end

  // Flatten per-channel counters onto the packed output bus
  always_comb begin
    evt_cnt = '0;
    for (int unsigned i = 0; i < N; i++)
      evt_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end

  // State registers: input history, stretch, output pulse, counters and overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      primed     <= 1'b0;
      in_q       <= '0;
      out_signal <= '0;
      ovf        <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        st_cnt[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      primed <= 1'b1;
      in_q   <= in_signal;
      for (int unsigned i = 0; i < N; i++) begin
        st_cnt[i]     <= st_nxt[i];
        out_signal[i] <= (st_nxt[i] != '0);
        // Clear wins over detection, but an event in the clear cycle is still counted
        if (clr_cnt) begin
          cnt[i] <= det[i] ? CNT_W'(1) : '0;
          ovf[i] <= 1'b0;
        end else if (det[i]) begin
          if (cnt[i] == '1)
            ovf[i] <= 1'b1;
          else
            cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef M_EDGE_MC_SVA_EN
  assume property (@(posedge clk) !$isunknown(edge_sel));

  for (genvar g = 0; g < N; g++) begin : g_sva
    a_det_pulse: assert property (@(posedge clk) disable iff (!rst_n)
      det[g] |=> out_signal[g]);
    a_max_len: assert property (@(posedge clk) disable iff (!rst_n)
      (!det[g]) [*STRETCH] |=> !out_signal[g]);
    a_cnt_mono: assert property (@(posedge clk) disable iff (!rst_n)
      !clr_cnt |=> cnt[g] >= $past(cnt[g]));
    a_ovf_max: assert property (@(posedge clk) disable iff (!rst_n)
      $rose(ovf[g]) |-> cnt[g] == '1);
  end
`endif

endmodule

// File: tb/tb_m_edge_mc.sv
// Self-checking bench for m_edge_mc: directed scenarios followed by random
// stimulus, all compared against a timestamp/integer reference model.
module tb_m_edge_mc;

  localparam int unsigned N       = 4;
  localparam int unsigned STRETCH = 2;
  localparam int unsigned CNT_W   = 2;
  localparam int          MAXC    = (1 << CNT_W) - 1;

  logic               clk;
  logic               rst_n;
  logic [N-1:0]       in_signal;
  logic [2*N-1:0]     edge_sel;
  logic               clr_cnt;
  logic [N-1:0]       out_signal;
  logic [N*CNT_W-1:0] evt_cnt;
  logic [N-1:0]       ovf;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_cyc;
  bit m_primed;
  bit m_prev     [N];
  int m_last_det [N];
  int m_cnt      [N];
  bit m_ovf      [N];

  m_edge_mc #(.N(N), .STRETCH(STRETCH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_signal  (in_signal),
    .edge_sel   (edge_sel),
    .clr_cnt    (clr_cnt),
    .out_signal (out_signal),
    .evt_cnt    (evt_cnt),
    .ovf        (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit want_edge(bit cur, bit prev, logic [1:0] sel);
    bit rose = cur && !prev;
    bit fell = !cur && prev;
    case (sel)
      2'd1:    return rose;
      2'd2:    return fell;
      2'd3:    return rose || fell;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_primed = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_prev[i]     = 1'b0;
      m_last_det[i] = -1000;
      m_cnt[i]      = 0;
      m_ovf[i]      = 1'b0;
    end
  endtask

  // Advance the model by one posedge using the currently applied inputs
  task automatic model_edge();
    m_cyc++;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) begin
        bit ev = m_primed && want_edge(in_signal[i], m_prev[i], edge_sel[2*i +: 2]);
        if (ev) m_last_det[i] = m_cyc;
        if (clr_cnt) begin
          m_cnt[i] = ev ? 1 : 0;
          m_ovf[i] = 1'b0;
        end else if (ev) begin
          if (m_cnt[i] == MAXC) m_ovf[i] = 1'b1;
          else m_cnt[i] = m_cnt[i] + 1;
        end
        m_prev[i] = in_signal[i];
      end
      m_primed = 1'b1;
    end
  endtask

  // One clock: update model at the edge, compare all outputs 1 ns later
  task automatic step();
    logic [N-1:0]       e_out;
    logic [N*CNT_W-1:0] e_cnt;
    logic [N-1:0]       e_ovf;
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < N; i++) begin
      e_out[i]                = (m_cyc - m_last_det[i]) < STRETCH;
      e_cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
      e_ovf[i]                = m_ovf[i];
    end
    check("out_signal", 64'(out_signal), 64'(e_out));
    check("evt_cnt",    64'(evt_cnt),    64'(e_cnt));
    check("ovf",        64'(ovf),        64'(e_ovf));
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  function automatic logic [CNT_W-1:0] ch_cnt(input int ch);
    return evt_cnt[ch*CNT_W +: CNT_W];
  endfunction

  initial begin
    m_cyc = 0;
    model_reset();
    rst_n     = 1'b0;
    in_signal = 4'b0001;
    edge_sel  = 8'h55;
    clr_cnt   = 1'b0;

    // Level high through reset release must not be reported
    steps(3);
    rst_n = 1'b1;
    steps(4);
    check("prime_out0", 64'(out_signal[0]), 64'd0);
    check("prime_cnt0", 64'(ch_cnt(0)), 64'd0);

    // Ch0 rise: 2-cycle pulse, one event
    in_signal = 4'b0000; step();
    in_signal = 4'b0001; step();
    check("ch0_pulse_c1", 64'(out_signal[0]), 64'd1);
    step();
    check("ch0_pulse_c2", 64'(out_signal[0]), 64'd1);
    step();
    check("ch0_pulse_end", 64'(out_signal[0]), 64'd0);
    check("ch0_cnt", 64'(ch_cnt(0)), 64'd1);

    // Ch1 both edges, then falling only
    edge_sel = 8'h5D;
    in_signal = 4'b0011; steps(4);
    in_signal = 4'b0001; steps(4);
    check("ch1_both_cnt", 64'(ch_cnt(1)), 64'd2);
    edge_sel = 8'h59;
    in_signal = 4'b0011; steps(4);
    in_signal = 4'b0001; steps(4);
    check("ch1_fall_cnt", 64'(ch_cnt(1)), 64'd3);

    // Ch2 rise then fall next cycle: one continuous 3-cycle pulse
    edge_sel = 8'h79;
    in_signal = 4'b0101; step();
    in_signal = 4'b0001; step();
    check("ch2_retrig_c2", 64'(out_signal[2]), 64'd1);
    step();
    check("ch2_retrig_c3", 64'(out_signal[2]), 64'd1);
    step();
    check("ch2_retrig_end", 64'(out_signal[2]), 64'd0);
    check("ch2_cnt", 64'(ch_cnt(2)), 64'd2);

    // Ch3 saturation, then clear together with a fifth rise
    for (int r = 0; r < 4; r++) begin
      in_signal = 4'b1001; step();
      in_signal = 4'b0001; step();
    end
    check("ch3_sat_cnt", 64'(ch_cnt(3)), 64'd3);
    check("ch3_sat_ovf", 64'(ovf[3]), 64'd1);
    in_signal = 4'b1001; clr_cnt = 1'b1; step();
    clr_cnt = 1'b0;
    check("ch3_clr_cnt", 64'(ch_cnt(3)), 64'd1);
    check("ch3_clr_ovf", 64'(ovf[3]), 64'd0);

    // Reset mid-pulse drops everything at that edge, priming repeats
    in_signal = 4'b0000; step();
    in_signal = 4'b0001; step();
    check("pre_rst_pulse", 64'(out_signal[0]), 64'd1);
    rst_n = 1'b0; step();
    check("rst_out", 64'(out_signal), 64'd0);
    check("rst_cnt", 64'(evt_cnt), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1; steps(2);
    check("reprime_out", 64'(out_signal), 64'd0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 1) == 0) in_signal = N'($urandom);
      if ($urandom_range(0, 15) == 0) edge_sel = (2*N)'($urandom);
      clr_cnt = ($urandom_range(0, 9) == 0);
      rst_n   = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/m_edge_mc.md
# m_edge_mc

Multi-channel, parametrised edge detector and pulse stretcher. Each of N input channels is sampled on `clk`. A configurable edge type (rise, fall, both, off) produces a registered output pulse of programmable length. Each channel also keeps a saturating event counter with a sticky overflow flag. The block replaces the single-channel `m_simple` detector in the SVA test designs and is the DUT for multi-channel assertion/assumption lint cases.

## Interface
Parameters:
- `N`, 4, number of channels (≥1)
- `STRETCH`, 2, output pulse length in clock cycles (≥1)
- `CNT_W`, 8, per-channel event counter width (≥2)

Ports:
- `clk`  input  1  clock; all logic on posedge
- `rst_n`  input  1  synchronous, active-low reset
- `in_signal`  input  N  channel inputs, already synchronous to `clk`
- `edge_sel`  input  2N  per-channel mode; bits [2i+1:2i] belong to channel i; 00 off, 01 rise, 10 fall, 11 both
- `clr_cnt`  input  1  synchronous clear of all counters and overflow flags
- `out_signal`  output  N  stretched detection pulse per channel
- `evt_cnt`  output  N*CNT_W  event counts; bits [CNT_W*(i+1)-1:CNT_W*i] belong to channel i
- `ovf`  output  N  sticky per-channel counter overflow flag

## Operation
- Per-channel state:
  - `in_q`, the previous sample
  - `st_cnt`, the stretch down-counter, width clog2(STRETCH+1)
  - `evt_cnt`, the event counter
  - `ovf`, the overflow flag
- Shared `primed` flag: cleared by reset, set at the first posedge after reset deasserts.
- Detection at posedge k, channel i, only when `primed`=1:
  - rise = in_signal[i] & ~in_q[i]
  - fall = ~in_signal[i] & in_q[i]
  - det = (sel==01 & rise) | (sel==10 & fall) | (sel==11 & (rise|fall)); sel 00 gives det=0.
- While `primed`=0, `in_q` loads `in_signal` and det is forced to 0. A level already high at reset release is therefore never reported as an edge.
- `edge_sel` is used combinationally in the same cycle. A mode change does not cancel a pulse already in progress.
- Stretch per channel:
  - det=1 loads `st_cnt`=STRETCH. This also applies while a pulse is active (retrigger extends the pulse, it does not add to it).
  - Otherwise `st_cnt` decrements if nonzero.
  - `out_signal[i]` is a register set to 1 exactly while `st_cnt` after update is nonzero.
- Counter per channel, with priority clr_cnt > det:
  - clr_cnt=1, det=0: evt_cnt←0, ovf←0.
  - clr_cnt=1, det=1: evt_cnt←1, ovf←0. The event in the clear cycle is counted.
  - clr_cnt=0, det=1, evt_cnt<2^CNT_W−1: evt_cnt←evt_cnt+1.
  - clr_cnt=0, det=1, evt_cnt=2^CNT_W−1: evt_cnt holds at max, ovf←1.
  - ovf stays 1 until clr_cnt or reset.
- Channels are fully independent. Simultaneous events on different channels are all processed in the same cycle.

## Timing
- Reset (rst_n=0 at posedge) clears:
  - out_signal to 0
  - evt_cnt to 0
  - ovf to 0
  - in_q to 0
  - st_cnt to 0
  - primed to 0
- A reset during an active pulse drops out_signal at that same posedge.
- Edge sampled at posedge k:
  - out_signal goes high after posedge k, observable from cycle k+1.
  - out_signal stays high for exactly STRETCH cycles and falls after posedge k+STRETCH.
  - There is no extra pipeline stage.
- Retrigger at posedge k+j with 1≤j<STRETCH: out_signal stays high through cycle k+j+STRETCH, with no low gap.
- evt_cnt and ovf update at posedge k and are visible from cycle k+1.
- First posedge after rst_n rises is the priming cycle: no detection. The earliest reportable edge is at the second posedge.
- Inputs are assumed stable around posedge. There is no internal synchroniser.

## Configuration
- `M_EDGE_MC_SVA_EN` defined: the module contains embedded concurrent assertions, all `disable iff (!rst_n)`:
  - det |=> out_signal for each channel
  - out_signal never high for more than STRETCH consecutive cycles without an intervening det
  - evt_cnt never decreases except on clr_cnt
  - $rose(ovf[i]) implies evt_cnt[i] is at max
  - an assume property that edge_sel has no X/Z
- `M_EDGE_MC_SVA_EN` undefined: no assertion or assumption code is compiled. Functional behaviour is identical.

## Test plan
- Reset, then hold in_signal=4'b0001 high through reset release, edge_sel=all 01 -> no out_signal pulse and evt_cnt[0]=0 (priming suppresses it).
- Ch0 rise at posedge 5, STRETCH=2 -> out_signal[0]=1 in cycles 6–7, 0 in cycle 8; evt_cnt[0]=1.
- Ch1 edge_sel=11, toggle 0→1→0 with 4 cycles between edges -> two 2-cycle pulses, evt_cnt[1]=2; repeat with edge_sel=10 -> only the falling edge counted.
- Ch2 rise, then fall 1 cycle later, edge_sel=11 -> one continuous 3-cycle pulse (retrigger), evt_cnt[2]=2.
- CNT_W=2, produce 4 rises on ch3 -> evt_cnt[3]=3, ovf[3]=1; then assert clr_cnt together with a 5th rise -> evt_cnt[3]=1, ovf[3]=0.
- Assert rst_n=0 for one cycle mid-pulse -> out_signal, evt_cnt and ovf all 0 at that posedge; priming repeats after release.
